dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, BUSY cycles without mem_ack before abort; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: memwrite  input  1  store request from the controller, held for the whole instruction.
REQ-005 Port: memread  input  1  load request from the controller (memtoreg), held for the whole instruction.
REQ-006 Port: addr  input  32  byte address (datapath aluout).
REQ-007 Port: wdata  input  32  store data (datapath writedata).
REQ-008 Port: rdata  output  32  load data to the datapath result mux (readdata).
REQ-009 Port: stall  output  1  freezes the PC and register-file write while high.
REQ-010 Port: err  output  1  sticky fault flag (misaligned access or timeout).
REQ-011 Port: mem_req  output  1  bus request to the memory.
REQ-012 Port: mem_we  output  1  bus write enable, valid while mem_req is high.
REQ-013 Port: mem_addr  output  30  bus word address, equal to addr[31:2].
REQ-014 Port: mem_wdata  output  32  bus write data.
REQ-015 Port: mem_rdata  input  32  bus read data, valid in the mem_ack cycle.
REQ-016 Port: mem_ack  input  1  single-cycle completion pulse from the memory.

Function
REQ-017 FSM states SHALL be IDLE, BUSY and DONE.
REQ-018 IDLE: a request is active when (memread|memwrite) is high and addr[1:0]==0.
- Active request: stall high combinationally.
- Next state BUSY.
- addr[31:2], wdata and mem_we = memwrite latched into bus registers.
REQ-019 memwrite and memread both high SHALL be treated as a write; rdata is 0 for that access.
REQ-020 mem_req SHALL equal (state==BUSY); mem_addr, mem_wdata and mem_we come only from the latched registers.
REQ-021 BUSY: stall high; an 8-bit cycle counter starts at 0 on BUSY entry and increments each BUSY cycle.
REQ-022 BUSY with mem_ack high: a read captures mem_rdata; next state DONE.
REQ-023 BUSY with no mem_ack and counter == TIMEOUT-1: next state DONE, capture register = 32'h0, err set.
REQ-024 DONE: stall low for exactly one cycle; rdata = capture register for a read, else 0; next state IDLE unconditionally.
- The request still present during DONE SHALL NOT be reissued.
REQ-025 rdata SHALL be 32'h0 in every state other than DONE.
REQ-026 mem_ack in IDLE or DONE SHALL be ignored.
REQ-027 Read latency: request seen in cycle 0, mem_req high from cycle 1, ack in cycle k, DONE (stall low, rdata valid) in cycle k+1.
REQ-028 Misaligned request (addr[1:0]!=0) in IDLE:
- No bus access; stall stays low.
- err is set at the next edge.
- rdata = 0.
REQ-029 err SHALL be sticky and cleared only by reset.

Reset
REQ-030 reset low SHALL immediately force these values, independent of clk:
- state = IDLE, counter = 0, err = 0.
- Capture and bus registers = 0.
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-031 reset asserted mid-BUSY SHALL abort the access with no DONE cycle; a later mem_ack is ignored.
REQ-032 The first request after reset deassertion SHALL be accepted on the first rising edge.

Verification
REQ-033 Load: addr=0x00000010, memread=1; ack on the 3rd BUSY cycle with mem_rdata=0xCAFEF00D.
- mem_addr=0x4 and mem_we=0 while mem_req is high.
- stall high for 4 cycles, then one DONE cycle with rdata=0xCAFEF00D, stall=0.
REQ-034 Store: addr=0x00000020, wdata=0x12345678, memwrite=1; ack on the 1st BUSY cycle.
- mem_we=1, mem_addr=0x8, mem_wdata=0x12345678.
- stall high 2 cycles; DONE rdata=0.
REQ-035 Timeout: TIMEOUT=4, load with no ack.
- mem_req high exactly 4 cycles.
- DONE rdata=0, err=1 and stays 1 through later good accesses.
REQ-036 Misaligned: addr=0x00000013, memread=1.
- mem_req never rises, stall=0, err=1 after one edge.
REQ-037 Reset mid-access: reset low in the 2nd BUSY cycle.
- mem_req=0 and stall=0 at once.
- An ack pulse after deassertion produces no DONE.
REQ-038 Back-to-back: two loads on consecutive instructions, each acked in the 1st BUSY cycle.
- Exactly two bus requests.
- The request cycle of the second load directly follows the DONE cycle of the first.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns a held load/store request into one handshaked
// bus transaction, stalling the core until it completes, faults or times out.
module dmem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] cap_q, cap_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;

  logic req_any, aligned, active;

  assign req_any = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);
  assign active  = req_any & aligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cap_d   = cap_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = BUSY;
          cnt_d   = 8'd0;
          addr_d  = addr[31:2];
          wdata_d = wdata;
          we_d    = memwrite;  // read+write together is a store
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (!we_q) cap_d = mem_rdata;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          cap_d   = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;  // the still-held request is not reissued
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      cap_q   <= 32'h0;
      addr_q  <= 30'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // stall is gated by reset so an aborted access releases the core at once
  assign stall     = reset & (((state_q == IDLE) & active) | (state_q == BUSY));
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = ((state_q == DONE) && !we_q) ? cap_q : 32'h0;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and randomized checks of dmem_ctrl against a transaction-level model.
module tb_dmem_ctrl;
  localparam int TO = 4;

  logic        clk, reset, memwrite, memread, stall, err, mem_req, mem_we, mem_ack;
  logic [31:0] addr, wdata, rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;

  int  npass = 0, ntot = 0, nreq = 0;
  bit  req_prev = 0;
  bit  err_exp = 0;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // count bus transactions as rising edges of mem_req
  always @(posedge clk) begin
    if (mem_req && !req_prev) nreq = nreq + 1;
    req_prev = mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    assert (got === want) npass++;
    else $error("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one instruction's memory access; returns just after the DONE-cycle edge
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rdv, input bit ack_in_done);
    int  n;
    bit  done, timed;
    memread = rd; memwrite = wr; addr = a; wdata = wd; mem_ack = 0; mem_rdata = 0;
    if (!(rd || wr) || a[1:0] != 2'b00) begin
      @(negedge clk);
      chk("mis_stall", stall, 0);
      chk("mis_req", mem_req, 0);
      chk("mis_rdata", rdata, 0);
      chk("mis_err_pre", err, err_exp);
      step();
      if (rd || wr) err_exp = 1;
      memread = 0; memwrite = 0;
      @(negedge clk);
      chk("mis_err_post", err, err_exp);
      chk("mis_req_post", mem_req, 0);
      step();
      return;
    end
    @(negedge clk);
    chk("req_stall", stall, 1);
    chk("req_memreq", mem_req, 0);
    chk("req_rdata", rdata, 0);
    step();
    n = 1; done = 0; timed = 0;
    while (!done) begin
      mem_ack   = (n == ack_at);
      mem_rdata = mem_ack ? rdv : $urandom;
      @(negedge clk);
      chk("busy_req", mem_req, 1);
      chk("busy_stall", stall, 1);
      chk("busy_we", mem_we, wr);
      chk("busy_addr", mem_addr, a[31:2]);
      chk("busy_wdata", mem_wdata, wd);
      chk("busy_rdata", rdata, 0);
      chk("busy_err", err, err_exp);
      if (n == ack_at) done = 1;
      else if (n == TO) begin done = 1; timed = 1; end
      n++;
      step();
    end
    if (timed) err_exp = 1;
    mem_ack = ack_in_done; mem_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", stall, 0);
    chk("done_req", mem_req, 0);
    chk("done_rdata", rdata, (wr || timed) ? 32'h0 : rdv);
    chk("done_err", err, err_exp);
    step();
    mem_ack = 0;
  endtask

  // no request; random stray acks must be ignored
  task automatic idle(input int cycles);
    memread = 0; memwrite = 0;
    for (int i = 0; i < cycles; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_stall", stall, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_rdata", rdata, 0);
      chk("idle_err", err, err_exp);
      step();
    end
    mem_ack = 0;
  endtask

  task automatic apply_reset();
    #1 reset = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", err, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    err_exp = 0;
    step();
    reset = 1;
  endtask

  initial begin
    int r0;
    logic [31:0] rv, a, wd;
    bit rd, wr;
    reset = 0; memread = 0; memwrite = 0; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #3;
    chk("por_req", mem_req, 0);
    chk("por_stall", stall, 0);
    chk("por_err", err, 0);
    chk("por_we", mem_we, 0);
    chk("por_addr", mem_addr, 0);
    chk("por_wdata", mem_wdata, 0);
    chk("por_rdata", rdata, 0);
    step();
    reset = 1;

    // load accepted on the first edge after reset release, acked on BUSY cycle 3
    access(1, 0, 32'h10, 32'h0, 3, 32'hCAFEF00D, 0);
    idle(1);
    access(0, 1, 32'h20, 32'h12345678, 1, 32'h0, 1);
    idle(1);

    // back-to-back loads: second request cycle immediately follows DONE
    r0 = nreq;
    access(1, 0, 32'h100, 32'h0, 1, 32'h11112222, 0);
    access(1, 0, 32'h104, 32'h0, 1, 32'h33334444, 0);
    idle(1);
    chk("b2b_nreq", nreq, r0 + 2);

    // reset in the second BUSY cycle aborts the access
    memread = 1; addr = 32'h40; wdata = 0;
    @(negedge clk); chk("mid_idle_stall", stall, 1); step();
    @(negedge clk); chk("mid_busy1", mem_req, 1); step();
    @(negedge clk); chk("mid_busy2", mem_req, 1);
    apply_reset();
    memread = 0;
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("mid_ack_stall", stall, 0);
    chk("mid_ack_req", mem_req, 0);
    step();
    mem_ack = 0;
    @(negedge clk);
    chk("mid_nodone_rdata", rdata, 0);
    chk("mid_nodone_stall", stall, 0);
    chk("mid_nodone_err", err, 0);
    step();

    // misaligned load never touches the bus
    r0 = nreq;
    access(1, 0, 32'h13, 32'h0, 1, 32'h0, 0);
    chk("mis_nreq", nreq, r0);
    chk("mis_err_set", err, 1);
    idle(1);

    // timeout on a fresh err flag; err then stays set through good accesses
    @(negedge clk);
    apply_reset();
    r0 = nreq;
    access(1, 0, 32'h200, 32'h0, 0, 32'h0, 0);
    chk("to_nreq", nreq, r0 + 1);
    access(1, 0, 32'h204, 32'h0, 2, 32'h5A5A5A5A, 0);
    access(0, 1, 32'h208, 32'hA5A5A5A5, 1, 32'h0, 0);
    chk("to_sticky", err, 1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      rv = $urandom;
      a  = {rv[31:2], 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom;
      case ($urandom_range(0, 2))
        0:       begin rd = 1; wr = 0; end
        1:       begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      access(rd, wr, a, wd, $urandom_range(1, TO + 1), $urandom,
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
